// File: rtl/telemetry_uart_tx.sv
// telemetry_uart_tx
//   Outbound half of the cold-storage serial link. Builds a fixed-format
//   ASCII status report "T<dd>H<dd>F<f>U<h>\r\n" and shifts it out as 8N1
//   UART on uart_txd. A report is sent periodically, on report_req, or both.
//   Requests that arrive while one is pending or a frame is in flight are
//   coalesced into a single pending report.
//
//   Optional feature (macro TELEM_ACK_EN): a rising edge of rx_msg_done
//   queues an acknowledge frame "K<cmd><v0><v1>\r\n". The ack takes
//   priority over a pending report.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   temperature  unsigned degrees C (shown as two saturated digits)
//   humidity     unsigned percent (shown as two saturated digits)
//   led_fan      cooling-fan state, sent as '1'/'0'
//   led_hum      humidifier state, sent as '1'/'0'
//   report_req   any cycle high requests one report
//   chr_cmd      last received command byte (ack frame only)
//   chr_val0     last received value byte 0 (ack frame only)
//   chr_val1     last received value byte 1 (ack frame only)
//   rx_msg_done  receive-complete flag; rising edge queues an ack
//   uart_txd     serial output, idle high
//   busy         high while a frame is being loaded or shifted
//   frame_done   one-cycle pulse after the last stop bit of a frame
module telemetry_uart_tx #(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int BAUD          = 9600,
  parameter int REPORT_PERIOD = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] temperature,
  input  logic [7:0] humidity,
  input  logic       led_fan,
  input  logic       led_hum,
  input  logic       report_req,
  input  logic [7:0] chr_cmd,
  input  logic [7:0] chr_val0,
  input  logic [7:0] chr_val1,
  input  logic       rx_msg_done,
  output logic       uart_txd,
  output logic       busy,
  output logic       frame_done
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int NBYTES   = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t      state_reg, state_next;
  logic [BW-1:0] baud_cnt_reg;
  logic [2:0]  bit_cnt_reg;
  logic [3:0]  byte_idx_reg;
  logic [7:0]  shift_reg;
  logic        rpt_pending_reg;
  logic        done_reg;
  logic        frame_is_ack_reg;
  logic [7:0]  frame_reg [NBYTES];

  logic        bit_end;
  logic        last_byte;
  logic        period_tick;
  logic        ack_pending;
  logic [7:0]  ack_cmd, ack_v0, ack_v1;
  logic [7:0]  load_bytes [NBYTES];
  logic [15:0] t_ascii, h_ascii;

  assign bit_end   = (baud_cnt_reg == BW'(BAUD_DIV - 1));
  assign last_byte = (byte_idx_reg == (frame_is_ack_reg ? 4'd5 : 4'd11));

  // Two ASCII digits of a value saturated at 99 ("07", "99", ...).
  function automatic logic [15:0] ascii_dec2(input logic [7:0] v);
    logic [7:0] sat, tens, units;
    sat   = (v > 8'd99) ? 8'd99 : v;
    tens  = sat / 8'd10;
    units = sat - tens * 8'd10;
    return {tens + 8'h30, units + 8'h30};
  endfunction

  // ---------------------------------------------------------------------
  // Free-running report period counter (independent of busy)
  // ---------------------------------------------------------------------
  generate
    if (REPORT_PERIOD > 0) begin : g_period
      logic [31:0] period_cnt_reg;
      assign period_tick = (period_cnt_reg == 32'(REPORT_PERIOD - 1));
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           period_cnt_reg <= '0;
        else if (period_tick) period_cnt_reg <= '0;
        else                  period_cnt_reg <= period_cnt_reg + 32'd1;
      end
    end else begin : g_no_period
      assign period_tick = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Acknowledge request capture
  // ---------------------------------------------------------------------
`ifdef TELEM_ACK_EN
  logic       rx_done_prev_reg;
  logic       ack_pending_reg;
  logic [7:0] ack_cmd_reg, ack_v0_reg, ack_v1_reg;
  logic       rx_rise;

  assign rx_rise = rx_msg_done & ~rx_done_prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_done_prev_reg <= 1'b0;
      ack_pending_reg  <= 1'b0;
      ack_cmd_reg      <= '0;
      ack_v0_reg       <= '0;
      ack_v1_reg       <= '0;
    end else begin
      rx_done_prev_reg <= rx_msg_done;
      // IDLE always consumes a pending ack; a new edge in that same cycle
      // still wins so it is not lost.
      ack_pending_reg  <= rx_rise | (ack_pending_reg & (state_reg != S_IDLE));
      if (rx_rise) begin
        ack_cmd_reg <= chr_cmd;
        ack_v0_reg  <= chr_val0;
        ack_v1_reg  <= chr_val1;
      end
    end
  end

  assign ack_pending = ack_pending_reg;
  assign ack_cmd     = ack_cmd_reg;
  assign ack_v0      = ack_v0_reg;
  assign ack_v1      = ack_v1_reg;
`else
  assign ack_pending = 1'b0;
  assign ack_cmd     = 8'h00;
  assign ack_v0      = 8'h00;
  assign ack_v1      = 8'h00;

  logic unused_ack_inputs;
  assign unused_ack_inputs = ^{chr_cmd, chr_val0, chr_val1, rx_msg_done};
`endif

  // ---------------------------------------------------------------------
  // Frame contents presented to LOAD
  // ---------------------------------------------------------------------
  always_comb begin
    t_ascii        = ascii_dec2(temperature);
    h_ascii        = ascii_dec2(humidity);
    load_bytes[0]  = 8'h54;                       // 'T'
    load_bytes[1]  = t_ascii[15:8];
    load_bytes[2]  = t_ascii[7:0];
    load_bytes[3]  = 8'h48;                       // 'H'
    load_bytes[4]  = h_ascii[15:8];
    load_bytes[5]  = h_ascii[7:0];
    load_bytes[6]  = 8'h46;                       // 'F'
    load_bytes[7]  = led_fan ? 8'h31 : 8'h30;
    load_bytes[8]  = 8'h55;                       // 'U'
    load_bytes[9]  = led_hum ? 8'h31 : 8'h30;
    load_bytes[10] = 8'h0D;
    load_bytes[11] = 8'h0A;
    if (frame_is_ack_reg) begin
      load_bytes[0] = 8'h4B;                      // 'K'
      load_bytes[1] = ack_cmd;
      load_bytes[2] = ack_v0;
      load_bytes[3] = ack_v1;
      load_bytes[4] = 8'h0D;
      load_bytes[5] = 8'h0A;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (ack_pending || rpt_pending_reg) state_next = S_LOAD;
      S_LOAD:  state_next = S_START;
      S_START: if (bit_end) state_next = S_DATA;
      S_DATA:  if (bit_end && (bit_cnt_reg == 3'd7)) state_next = S_STOP;
      S_STOP:  if (bit_end) state_next = last_byte ? S_IDLE : S_START;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    uart_txd   = 1'b1;
    busy       = (state_reg != S_IDLE);
    frame_done = done_reg;
    case (state_reg)
      S_START: uart_txd = 1'b0;
      S_DATA:  uart_txd = shift_reg[0];
      default: uart_txd = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath: counters, shifter, snapshot, pending report flag
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt_reg     <= '0;
      bit_cnt_reg      <= '0;
      byte_idx_reg     <= '0;
      shift_reg        <= '1;
      rpt_pending_reg  <= 1'b0;
      done_reg         <= 1'b0;
      frame_is_ack_reg <= 1'b0;
      for (int i = 0; i < NBYTES; i++) frame_reg[i] <= '0;
    end else begin
      // A report request always wins over the IDLE clear, so a request in
      // the same cycle as the hand-off is not dropped.
      rpt_pending_reg <= report_req | period_tick |
                         (rpt_pending_reg & ~((state_reg == S_IDLE) & ~ack_pending));

      done_reg <= (state_reg == S_STOP) && bit_end && last_byte;

      if (state_reg == S_IDLE) frame_is_ack_reg <= ack_pending;

      if ((state_reg == S_START) || (state_reg == S_DATA) || (state_reg == S_STOP))
        baud_cnt_reg <= bit_end ? '0 : baud_cnt_reg + 1'b1;
      else
        baud_cnt_reg <= '0;

      if (state_reg != S_DATA)
        bit_cnt_reg <= '0;
      else if (bit_end)
        bit_cnt_reg <= bit_cnt_reg + 3'd1;

      if (state_reg == S_LOAD) begin
        byte_idx_reg <= '0;
        for (int i = 0; i < NBYTES; i++) frame_reg[i] <= load_bytes[i];
      end else if ((state_reg == S_STOP) && bit_end && !last_byte) begin
        byte_idx_reg <= byte_idx_reg + 4'd1;
      end

      // The byte is fetched at the end of the start bit and shifted LSB first.
      if ((state_reg == S_START) && bit_end)
        shift_reg <= frame_reg[byte_idx_reg];
      else if ((state_reg == S_DATA) && bit_end)
        shift_reg <= {1'b1, shift_reg[7:1]};
    end
  end

endmodule

// File: tb/tb_telemetry_uart_tx.sv
module tb_telemetry_uart_tx;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int BD       = 10;
  localparam int FRAME_CY = 12 * 10 * BD;
  localparam int PERIOD   = 2000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rst_p_n = 1'b0;
  logic [7:0] temperature = '0, humidity = '0;
  logic [7:0] chr_cmd = '0, chr_val0 = '0, chr_val1 = '0;
  logic       led_fan = 1'b0, led_hum = 1'b0, report_req = 1'b0, rx_msg_done = 1'b0;
  logic       p_req = 1'b0, p_rx_done = 1'b0;
  logic       uart_txd, busy, frame_done;
  logic       txd_p, busy_p, frame_done_p;

  int checks_cnt = 0;
  int errors_cnt = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  telemetry_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .REPORT_PERIOD(0)) dut (
    .clk(clk), .rst_n(rst_n), .temperature(temperature), .humidity(humidity),
    .led_fan(led_fan), .led_hum(led_hum), .report_req(report_req),
    .chr_cmd(chr_cmd), .chr_val0(chr_val0), .chr_val1(chr_val1),
    .rx_msg_done(rx_msg_done), .uart_txd(uart_txd), .busy(busy),
    .frame_done(frame_done)
  );

  telemetry_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .REPORT_PERIOD(PERIOD)) dut_p (
    .clk(clk), .rst_n(rst_p_n), .temperature(temperature), .humidity(humidity),
    .led_fan(led_fan), .led_hum(led_hum), .report_req(p_req),
    .chr_cmd(chr_cmd), .chr_val0(chr_val0), .chr_val1(chr_val1),
    .rx_msg_done(p_rx_done), .uart_txd(txd_p), .busy(busy_p),
    .frame_done(frame_done_p)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // UART receiver on the main DUT: mid-bit sampling at falling clock edges.
  byte unsigned rx_q[$];
  int           rx_start_q[$];
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && uart_txd === 1'b0) begin
        int t0;
        logic [7:0] b;
        t0 = cyc;
        repeat (BD / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          b[i] = uart_txd;
        end
        repeat (BD) @(negedge clk);
        check_eq("stop_bit", 32'(uart_txd), 32'd1);
        rx_q.push_back(b);
        rx_start_q.push_back(t0);
      end
    end
  end

  int fd_q[$];
  always @(negedge clk) if (frame_done === 1'b1) fd_q.push_back(cyc);

  // Start-bit times of the periodic instance.
  int p_starts[$];
  bit p_in_frame = 1'b0;
  always @(negedge clk) begin
    if (frame_done_p === 1'b1) p_in_frame = 1'b0;
    if (rst_p_n && txd_p === 1'b0 && !p_in_frame) begin
      p_starts.push_back(cyc);
      p_in_frame = 1'b1;
    end
  end

  // Reference model: expected byte stream built from the frame format.
  byte unsigned exp_q[$];

  task automatic push_report(input int t, input int h, input bit f, input bit u);
    string s;
    s = $sformatf("T%02dH%02dF%0dU%0d", (t > 99) ? 99 : t, (h > 99) ? 99 : h, f, u);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic push_ack(input byte unsigned c, input byte unsigned v0, input byte unsigned v1);
    exp_q.push_back(8'h4B);
    exp_q.push_back(c);
    exp_q.push_back(v0);
    exp_q.push_back(v1);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic check_rx(input string tag);
    byte unsigned e;
    logic [31:0]  got;
    int           n;
    n = exp_q.size();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rx_q.size() > 0) got = 32'(rx_q.pop_front());
      else                 got = 32'h100;
      check_eq(tag, got, 32'(e));
    end
    check_eq({tag, "_extra"}, 32'(rx_q.size()), 32'd0);
    rx_start_q.delete();
    $display("frame %s: %0d bytes compared at cycle %0d", tag, n, cyc);
  endtask

  task automatic pulse_req(output int k);
    @(negedge clk);
    report_req = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    report_req = 1'b0;
  endtask

  task automatic wait_fd(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (fd_q.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (fd_q.size() < target) check_eq({tag, "_timeout"}, 32'(fd_q.size()), 32'(target));
  endtask

  function automatic int start_at(input int i);
    return (rx_start_q.size() > i) ? rx_start_q[i] : -1;
  endfunction

  function automatic int fd_at(input int i);
    return (fd_q.size() > i) ? fd_q[i] : -1;
  endfunction

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, base, t, h, low_cnt;
    bit f, u;

    // Reset state
    #1;
    check_eq("rst_txd", 32'(uart_txd), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(frame_done), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rst_p_n = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("idle_txd", 32'(uart_txd), 32'd1);
    check_eq("idle_busy", 32'(busy), 32'd0);

    // Basic frame, latency and frame timing
    temperature = 8'd23; humidity = 8'd45; led_fan = 1'b1; led_hum = 1'b0;
    base = fd_q.size();
    pulse_req(k);
    wait_fd(base + 1, 3000, "basic");
    check_eq("start_latency", 32'(start_at(0)), 32'(k + 2));
    check_eq("done_time", 32'(fd_at(base)), 32'(start_at(0) + FRAME_CY));
    @(negedge clk);
    check_eq("busy_after", 32'(busy), 32'd0);
    check_eq("done_pulse_width", 32'(frame_done), 32'd0);
    push_report(23, 45, 1'b1, 1'b0);
    check_rx("basic");

    // Padding, saturation and random values
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: begin t = 7;   h = 150; f = 1'b0; u = 1'b1; end
        1: begin t = 0;   h = 0;   f = 1'b1; u = 1'b1; end
        2: begin t = 99;  h = 100; f = 1'b0; u = 1'b0; end
        3: begin t = 255; h = 9;   f = 1'b1; u = 1'b0; end
        default: begin
          t = int'($urandom_range(0, 255)); h = int'($urandom_range(0, 255));
          f = 1'($urandom); u = 1'($urandom);
        end
      endcase
      temperature = 8'(t); humidity = 8'(h); led_fan = f; led_hum = u;
      base = fd_q.size();
      pulse_req(k);
      wait_fd(base + 1, 3000, "value");
      push_report(t, h, f, u);
      check_rx($sformatf("value%0d", i));
    end

    // Snapshot and coalescing
    temperature = 8'd23; humidity = 8'd60; led_fan = 1'b0; led_hum = 1'b1;
    base = fd_q.size();
    pulse_req(k);
    repeat (300) @(negedge clk);
    temperature = 8'd30;
    for (int i = 0; i < 3; i++) begin
      repeat (100) @(negedge clk);
      pulse_req(t);
    end
    wait_fd(base + 2, 4000, "coalesce");
    check_eq("b2b_start", 32'(start_at(12)), 32'(fd_at(base) + 2));
    repeat (1500) @(negedge clk);
    check_eq("coalesce_count", 32'(fd_q.size()), 32'(base + 2));
    push_report(23, 60, 1'b0, 1'b1);
    push_report(30, 60, 1'b0, 1'b1);
    check_rx("coalesce");

    // Reset abort during the 5th byte
    pulse_req(k);
    repeat (452) @(negedge clk);
    base = fd_q.size();
    rst_n = 1'b0;
    #1;
    check_eq("abort_txd", 32'(uart_txd), 32'd1);
    check_eq("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || busy !== 1'b0) low_cnt++;
    end
    check_eq("abort_no_done", 32'(fd_q.size()), 32'(base));
    check_eq("abort_quiet", 32'(low_cnt), 32'd0);
    rx_q.delete();
    rx_start_q.delete();
    temperature = 8'd5; humidity = 8'd77; led_fan = 1'b1; led_hum = 1'b1;
    base = fd_q.size();
    pulse_req(k);
    wait_fd(base + 1, 3000, "after_abort");
    check_eq("after_abort_lat", 32'(start_at(0)), 32'(k + 2));
    push_report(5, 77, 1'b1, 1'b1);
    check_rx("after_abort");

`ifdef TELEM_ACK_EN
    // Ack frame simultaneous with a report request: ack goes first
    chr_cmd = 8'h41; chr_val0 = 8'h31; chr_val1 = 8'h38;
    temperature = 8'd12; humidity = 8'd34;
    base = fd_q.size();
    @(negedge clk);
    rx_msg_done = 1'b1;
    report_req = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    report_req = 1'b0;
    chr_cmd = 8'h5A;
    wait_fd(base + 2, 4000, "ack");
    check_eq("ack_latency", 32'(start_at(0)), 32'(k + 2));
    rx_msg_done = 1'b0;
    push_ack(8'h41, 8'h31, 8'h38);
    push_report(12, 34, 1'b1, 1'b1);
    check_rx("ack");
`else
    // Without the ack feature rx_msg_done must not start a frame
    base = fd_q.size();
    @(negedge clk);
    rx_msg_done = 1'b1;
    repeat (5) @(negedge clk);
    rx_msg_done = 1'b0;
    repeat (1500) @(negedge clk);
    check_eq("no_ack_frames", 32'(fd_q.size()), 32'(base));
    check_eq("no_ack_bytes", 32'(rx_q.size()), 32'd0);
`endif

    // Periodic instance: start bits exactly PERIOD apart
    check_eq("period_frames", 32'(p_starts.size() >= 5), 32'd1);
    for (int i = 1; i < 5; i++) begin
      if (p_starts.size() > i) begin
        check_eq($sformatf("period_gap%0d", i), 32'(p_starts[i] - p_starts[i-1]), 32'(PERIOD));
        $display("periodic frame %0d start=%0d", i, p_starts[i]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
